// File: rtl/stash_scan_sequencer_if.sv
// Bundle of every signal between the stash scan sequencer and its neighbours
// (stash control FSM, stash tag RAM, stash scan table and writeback engine).
// Signal suffixes are taken from the sequencer's point of view.
//   master : sequencer side  (drives *_o, samples *_i)
//   slave  : environment side (drives *_i, samples *_o)
interface stash_scan_sequencer_if #(
    parameter int ORAML    = 16,
    parameter int SEAWidth = 7,
    parameter int STAWidth = 7
);
    logic                access_start_i;
    logic [ORAML-1:0]    access_leaf_i;
    logic [ORAML-1:0]    current_leaf_o;
    logic                per_access_reset_o;
    logic                table_reset_done_i;
    logic [SEAWidth-1:0] stash_rd_addr_o;
    logic                stash_rd_en_o;
    logic                stash_entry_valid_i;
    logic [ORAML-1:0]    stash_entry_leaf_i;
    logic [ORAML-1:0]    scan_leaf_o;
    logic [SEAWidth-1:0] scan_s_addr_o;
    logic                scan_valid_o;
    logic                scan_done_o;
    logic                is_writeback_cand_o;
    logic                scan_rslt_valid_i;
    logic                scan_rslt_accept_i;
    logic                writeback_ready_i;
    logic [STAWidth-1:0] dma_addr_o;
    logic                dma_valid_o;
    logic [STAWidth-1:0] accepted_count_o;
    logic                busy_o;
    logic                done_o;
    logic                error_o;

    modport master (
        input  access_start_i, access_leaf_i, table_reset_done_i,
               stash_entry_valid_i, stash_entry_leaf_i,
               scan_rslt_valid_i, scan_rslt_accept_i, writeback_ready_i,
        output current_leaf_o, per_access_reset_o, stash_rd_addr_o, stash_rd_en_o,
               scan_leaf_o, scan_s_addr_o, scan_valid_o, scan_done_o,
               is_writeback_cand_o, dma_addr_o, dma_valid_o, accepted_count_o,
               busy_o, done_o, error_o
    );

    modport slave (
        output access_start_i, access_leaf_i, table_reset_done_i,
               stash_entry_valid_i, stash_entry_leaf_i,
               scan_rslt_valid_i, scan_rslt_accept_i, writeback_ready_i,
        input  current_leaf_o, per_access_reset_o, stash_rd_addr_o, stash_rd_en_o,
               scan_leaf_o, scan_s_addr_o, scan_valid_o, scan_done_o,
               is_writeback_cand_o, dma_addr_o, dma_valid_o, accepted_count_o,
               busy_o, done_o, error_o
    );
endinterface

// File: rtl/stash_scan_sequencer.sv
// Per-access controller for the stash scan table.
// Sequence per access: pulse the table's per-access reset and wait out its
// SNULL re-init (RINIT), stream every stash tag into the scan port (SCAN),
// wait for all scan results (DRAIN), walk every scan-table address toward
// writeback (DMA), then pulse Done (FIN).
// Ports:
//   clk  - system clock
//   rst  - asynchronous, active-high reset
//   bus  - stash_scan_sequencer_if.master carrying access control, stash tag
//          read, scan request/result, writeback address and status signals.
// All outputs are registered except scan_leaf_o, scan_s_addr_o's qualifier
// scan_valid_o and scan_leaf_o, which follow the tag RAM read data directly.
module stash_scan_sequencer #(
    parameter int ORAML        = 16,
    parameter int ORAMZ        = 4,
    parameter int StashEntries = 128,
    parameter int SEAWidth     = 7,
    parameter int BlocksOnPath = ORAMZ * (ORAML + 1),
    parameter int STAWidth     = 7
) (
    input  logic clk,
    input  logic rst,
    stash_scan_sequencer_if.master bus
);
    localparam int WaitW = 8;
    localparam int OutW  = SEAWidth + 1;
    // RINIT counts 0..BlocksOnPath+1, i.e. BlocksOnPath+2 cycles
    localparam logic [WaitW-1:0]    WaitLast = WaitW'(BlocksOnPath + 1);
    localparam logic [SEAWidth-1:0] RdLast   = SEAWidth'(StashEntries - 1);
    localparam logic [STAWidth-1:0] DmaLast  = STAWidth'(BlocksOnPath - 1);
    localparam logic [STAWidth-1:0] AccMax   = STAWidth'(BlocksOnPath);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RINIT = 3'd1,
        S_SCAN  = 3'd2,
        S_DRAIN = 3'd3,
        S_DMA   = 3'd4,
        S_FIN   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [ORAML-1:0]    leaf_q;
    logic                par_q;
    logic [WaitW-1:0]    wait_q;
    logic                rd_en_q;
    logic [SEAWidth-1:0] rd_addr_q;
    logic                rd_pend_q;      // tag read data is on the bus this cycle
    logic [SEAWidth-1:0] sa_q;           // address of the read now returning
    logic [OutW-1:0]     out_q, out_d;   // scan requests awaiting a result
    logic [STAWidth-1:0] acc_q, acc_d;
    logic                err_q;
    logic [STAWidth-1:0] ptr_q;
    logic                dma_last_q;     // final address is being presented
    logic                dma_valid_q;
    logic [STAWidth-1:0] dma_addr_q;
    logic                scan_done_q;
    logic                wb_cand_q;
    logic                busy_q;
    logic                done_q;

    logic start_s;
    logic scan_valid_s;
    logic stray_s;
    logic sat_s;

    assign start_s      = bus.access_start_i && (state_q == S_IDLE);
    assign scan_valid_s = rd_pend_q && bus.stash_entry_valid_i;

    // Outstanding-request counter next value; flags results with nothing pending
    always_comb begin
        out_d   = out_q;
        stray_s = bus.scan_rslt_valid_i && (out_q == {OutW{1'b0}});
        if (start_s) begin
            out_d = {OutW{1'b0}};
        end else if (scan_valid_s && bus.scan_rslt_valid_i) begin
            out_d = out_q;
        end else if (scan_valid_s) begin
            out_d = out_q + OutW'(1);
        end else if (bus.scan_rslt_valid_i && !stray_s) begin
            out_d = out_q - OutW'(1);
        end else begin
            out_d = out_q;
        end
    end

    // Accepted-block counter next value, saturating at the path capacity
    always_comb begin
        acc_d = acc_q;
        sat_s = 1'b0;
        if (start_s) begin
            acc_d = {STAWidth{1'b0}};
        end else if (bus.scan_rslt_valid_i && bus.scan_rslt_accept_i) begin
            if (acc_q == AccMax) begin
                sat_s = 1'b1;
            end else begin
                acc_d = acc_q + STAWidth'(1);
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Next-state logic for the access sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.access_start_i) state_d = S_RINIT;
                else                    state_d = S_IDLE;
            end
            S_RINIT: begin
                if ((wait_q == WaitLast) && bus.table_reset_done_i) state_d = S_SCAN;
                else                                                  state_d = S_RINIT;
            end
            S_SCAN: begin
                // last read has been issued and its data is returning now
                if (rd_pend_q && !rd_en_q) state_d = S_DRAIN;
                else                       state_d = S_SCAN;
            end
            S_DRAIN: begin
                // uses the post-update count so the last result cycle is the final DRAIN cycle
                if (out_d == {OutW{1'b0}}) state_d = S_DMA;
                else                       state_d = S_DRAIN;
            end
            S_DMA: begin
                if (dma_last_q) state_d = S_FIN;
                else            state_d = S_DMA;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            leaf_q      <= {ORAML{1'b0}};
            par_q       <= 1'b0;
            wait_q      <= {WaitW{1'b0}};
            rd_en_q     <= 1'b0;
            rd_addr_q   <= {SEAWidth{1'b0}};
            rd_pend_q   <= 1'b0;
            sa_q        <= {SEAWidth{1'b0}};
            out_q       <= {OutW{1'b0}};
            acc_q       <= {STAWidth{1'b0}};
            err_q       <= 1'b0;
            ptr_q       <= {STAWidth{1'b0}};
            dma_last_q  <= 1'b0;
            dma_valid_q <= 1'b0;
            dma_addr_q  <= {STAWidth{1'b0}};
            scan_done_q <= 1'b0;
            wb_cand_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            acc_q   <= acc_d;
            err_q   <= err_q | stray_s | sat_s;
            par_q   <= start_s;
            if (start_s) leaf_q <= bus.access_leaf_i;

            if (state_q == S_RINIT) begin
                if (wait_q != WaitLast) wait_q <= wait_q + WaitW'(1);
            end else begin
                wait_q <= {WaitW{1'b0}};
            end

            rd_pend_q <= rd_en_q;
            sa_q      <= rd_addr_q;
            if ((state_q == S_RINIT) && (state_d == S_SCAN)) begin
                rd_en_q   <= 1'b1;
                rd_addr_q <= {SEAWidth{1'b0}};
            end else if (rd_en_q) begin
                if (rd_addr_q == RdLast) rd_en_q   <= 1'b0;
                else                     rd_addr_q <= rd_addr_q + SEAWidth'(1);
            end

            dma_valid_q <= 1'b0;
            if (state_q != S_DMA) begin
                ptr_q      <= {STAWidth{1'b0}};
                dma_last_q <= 1'b0;
            end else if (!dma_last_q && bus.writeback_ready_i) begin
                dma_valid_q <= 1'b1;
                dma_addr_q  <= ptr_q;
                ptr_q       <= ptr_q + STAWidth'(1);
                if (ptr_q == DmaLast) dma_last_q <= 1'b1;
            end

            scan_done_q <= (state_q == S_SCAN) && (state_d == S_DRAIN);
            wb_cand_q   <= (state_d == S_SCAN) || (state_d == S_DRAIN);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
        end
    end

    assign bus.current_leaf_o      = leaf_q;
    assign bus.per_access_reset_o  = par_q;
    assign bus.stash_rd_addr_o     = rd_addr_q;
    assign bus.stash_rd_en_o       = rd_en_q;
    assign bus.scan_valid_o        = scan_valid_s;
    assign bus.scan_s_addr_o       = sa_q;
    assign bus.scan_leaf_o         = rd_pend_q ? bus.stash_entry_leaf_i : {ORAML{1'b0}};
    assign bus.scan_done_o         = scan_done_q;
    assign bus.is_writeback_cand_o = wb_cand_q;
    assign bus.dma_addr_o          = dma_addr_q;
    assign bus.dma_valid_o         = dma_valid_q;
    assign bus.accepted_count_o    = acc_q;
    assign bus.busy_o              = busy_q;
    assign bus.done_o              = done_q;
    assign bus.error_o             = err_q;
endmodule

// File: tb/tb_stash_scan_sequencer.sv
// Directed bench for stash_scan_sequencer: models the stash tag RAM (1-cycle
// read) and a scan table with programmable result latency.
module tb_stash_scan_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stash_scan_sequencer_if bus ();

    stash_scan_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic        st_valid [0:127];
    logic [15:0] st_leaf  [0:127];
    logic [7:0]  rpipe = 8'd0;
    logic [2:0]  lat = 3'd1;
    logic        accept_en = 1'b1;

    // tag RAM and scan-table result pipeline models
    always @(posedge clk) begin
        if (rst) begin
            bus.stash_entry_valid_i <= 1'b0;
            bus.stash_entry_leaf_i  <= 16'h0000;
            rpipe                   <= 8'd0;
        end else begin
            bus.stash_entry_valid_i <= bus.stash_rd_en_o ? st_valid[bus.stash_rd_addr_o] : 1'b0;
            bus.stash_entry_leaf_i  <= bus.stash_rd_en_o ? st_leaf[bus.stash_rd_addr_o] : 16'h0000;
            rpipe                   <= {rpipe[6:0], bus.scan_valid_o};
        end
    end
    assign bus.scan_rslt_valid_i  = rpipe[lat - 3'd1];
    assign bus.scan_rslt_accept_i = bus.scan_rslt_valid_i & accept_en;

    // per-run statistics gathered by run_access
    int n_scan, n_scandone, n_dma, n_done, dma_seq_err, scan_data_err;
    int par_cyc, first_rd, first_dma, last_dma, last_rslt, done_cyc;
    int bp_mode, inject, inject_cyc;
    logic [15:0] leaf_after;
    logic        busy_after;
    logic        wb_hist [0:4095];

    task automatic set_stash(input int lo, input int hi);
        for (int i = 0; i < 128; i++) begin
            st_valid[i] = (i >= lo) && (i <= hi);
            st_leaf[i]  = 16'h1000 + 16'(i * 7);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // start an access and observe it until Done (returns on the Done negedge)
    task automatic run_access(input logic [15:0] leaf);
        int cyc;
        n_scan = 0; n_scandone = 0; n_dma = 0; n_done = 0; dma_seq_err = 0;
        scan_data_err = 0; par_cyc = -1; first_rd = -1; first_dma = -1;
        last_dma = -1; last_rslt = -1; done_cyc = -1; inject_cyc = -1;
        @(negedge clk);
        bus.access_start_i = 1'b1;
        bus.access_leaf_i  = leaf;
        @(negedge clk);
        bus.access_start_i = 1'b0;
        cyc = 1;
        while (cyc < 4000) begin
            bus.access_start_i = 1'b0;
            wb_hist[cyc] = bus.is_writeback_cand_o;
            if (bus.per_access_reset_o && par_cyc < 0) par_cyc = cyc;
            if (bus.stash_rd_en_o && first_rd < 0) first_rd = cyc;
            if (bus.scan_done_o) n_scandone++;
            if (bus.scan_rslt_valid_i) last_rslt = cyc;
            if (bus.scan_valid_o) begin
                n_scan++;
                if (!st_valid[bus.scan_s_addr_o] || bus.scan_leaf_o !== st_leaf[bus.scan_s_addr_o])
                    scan_data_err++;
            end
            if (bus.dma_valid_o) begin
                if (int'(bus.dma_addr_o) != n_dma) dma_seq_err++;
                if (first_dma < 0) first_dma = cyc;
                last_dma = cyc;
                n_dma++;
            end
            if (inject_cyc > 0 && cyc == inject_cyc + 1) begin
                leaf_after = bus.current_leaf_o;
                busy_after = bus.busy_o;
            end
            if (inject != 0 && n_dma == 10 && inject_cyc < 0) begin
                bus.access_start_i = 1'b1;
                bus.access_leaf_i  = 16'h1234;
                inject_cyc = cyc;
            end
            if (bus.done_o) begin
                n_done++;
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            if (bp_mode != 0) bus.writeback_ready_i = ~bus.writeback_ready_i;
            cyc++;
        end
        total++;
        if (n_done == 0) begin
            bad++;
            $display("FAIL run_timeout: done seen %0d times, required 1", n_done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({bus.busy_o, bus.done_o, bus.error_o, bus.dma_valid_o, bus.per_access_reset_o,
             bus.stash_rd_en_o, bus.scan_valid_o, bus.scan_done_o, bus.is_writeback_cand_o} !== 9'd0) begin
            bad++; $display("FAIL reset_flags: got %b required 0", {bus.busy_o, bus.done_o, bus.error_o,
                bus.dma_valid_o, bus.per_access_reset_o, bus.stash_rd_en_o, bus.scan_valid_o,
                bus.scan_done_o, bus.is_writeback_cand_o});
        end
        total++;
        if (bus.current_leaf_o !== 16'h0000 || bus.accepted_count_o !== 7'd0 || bus.dma_addr_o !== 7'd0) begin
            bad++; $display("FAIL reset_values: leaf=%h acc=%0d dma=%0d required 0", bus.current_leaf_o,
                bus.accepted_count_o, bus.dma_addr_o);
        end
    endtask

    task automatic test_reset_mid_scan();
        int k;
        set_stash(0, 127);
        @(negedge clk);
        bus.access_start_i = 1'b1;
        bus.access_leaf_i  = 16'hA5A5;
        @(negedge clk);
        bus.access_start_i = 1'b0;
        k = 0;
        while (!bus.stash_rd_en_o && k < 200) begin @(negedge clk); k++; end
        total++;
        if (bus.stash_rd_en_o !== 1'b1) begin bad++; $display("FAIL t1_reach_scan: rd_en=%b required 1", bus.stash_rd_en_o); end
        repeat (20) @(negedge clk);
        total++;
        if (bus.scan_valid_o !== 1'b1 || bus.current_leaf_o !== 16'hA5A5) begin
            bad++; $display("FAIL t1_mid_scan: scan_valid=%b leaf=%h required 1 a5a5", bus.scan_valid_o, bus.current_leaf_o);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.busy_o, bus.stash_rd_en_o, bus.scan_valid_o, bus.is_writeback_cand_o} !== 4'd0) begin
            bad++; $display("FAIL t1_async_flags: got %b required 0000", {bus.busy_o, bus.stash_rd_en_o,
                bus.scan_valid_o, bus.is_writeback_cand_o});
        end
        total++;
        if (bus.current_leaf_o !== 16'h0000 || bus.stash_rd_addr_o !== 7'd0 || bus.scan_s_addr_o !== 7'd0) begin
            bad++; $display("FAIL t1_async_values: leaf=%h rd=%0d sa=%0d required 0", bus.current_leaf_o,
                bus.stash_rd_addr_o, bus.scan_s_addr_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.access_start_i = 1'b1;
        bus.access_leaf_i  = 16'h0F0F;
        @(negedge clk);
        bus.access_start_i = 1'b0;
        total++;
        if (bus.busy_o !== 1'b1 || bus.per_access_reset_o !== 1'b1 || bus.current_leaf_o !== 16'h0F0F) begin
            bad++; $display("FAIL t1_restart: busy=%b par=%b leaf=%h required 1 1 0f0f", bus.busy_o,
                bus.per_access_reset_o, bus.current_leaf_o);
        end
        do_reset();
    endtask

    task automatic test_rinit_hold();
        int k;
        set_stash(1, 0);
        bus.table_reset_done_i = 1'b0;
        @(negedge clk);
        bus.access_start_i = 1'b1;
        bus.access_leaf_i  = 16'h0001;
        @(negedge clk);
        bus.access_start_i = 1'b0;
        repeat (80) @(negedge clk);
        total++;
        if (bus.stash_rd_en_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            bad++; $display("FAIL rinit_hold: rd_en=%b busy=%b required 0 1", bus.stash_rd_en_o, bus.busy_o);
        end
        bus.table_reset_done_i = 1'b1;
        @(negedge clk);
        total++;
        if (bus.stash_rd_en_o !== 1'b1) begin bad++; $display("FAIL rinit_release: rd_en=%b required 1", bus.stash_rd_en_o); end
        k = 0;
        while (!bus.done_o && k < 1000) begin @(negedge clk); k++; end
        total++;
        if (bus.done_o !== 1'b1) begin bad++; $display("FAIL rinit_finish: done=%b required 1", bus.done_o); end
        do_reset();
    endtask

    task automatic test_empty_stash();
        set_stash(1, 0);
        run_access(16'h00AA);
        total++;
        if (first_rd - par_cyc != 70) begin bad++; $display("FAIL empty_rinit_len: got %0d required 70", first_rd - par_cyc); end
        total++;
        if (n_scan != 0 || n_scandone != 1) begin
            bad++; $display("FAIL empty_scan: scans=%0d scandone=%0d required 0 1", n_scan, n_scandone);
        end
        total++;
        if (n_dma != 68 || dma_seq_err != 0 || last_dma - first_dma != 67) begin
            bad++; $display("FAIL empty_dma: n=%0d seqerr=%0d span=%0d required 68 0 67", n_dma, dma_seq_err, last_dma - first_dma);
        end
        total++;
        if (done_cyc != last_dma + 1 || bus.busy_o !== 1'b1 || bus.accepted_count_o !== 7'd0) begin
            bad++; $display("FAIL empty_done: done_cyc=%0d last_dma=%0d busy=%b acc=%0d required last+1 1 0",
                done_cyc, last_dma, bus.busy_o, bus.accepted_count_o);
        end
    endtask

    task automatic test_full_path();
        set_stash(10, 77);
        run_access(16'h0042);
        total++;
        if (n_scan != 68 || scan_data_err != 0) begin
            bad++; $display("FAIL full_scan: scans=%0d dataerr=%0d required 68 0", n_scan, scan_data_err);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus.accepted_count_o !== 7'd68 || bus.error_o !== 1'b0 || bus.current_leaf_o !== 16'h0042) begin
            bad++; $display("FAIL full_count: acc=%0d err=%b leaf=%h required 68 0 0042", bus.accepted_count_o,
                bus.error_o, bus.current_leaf_o);
        end
        set_stash(10, 78);
        run_access(16'h0043);
        total++;
        if (n_scan != 69 || bus.accepted_count_o !== 7'd68 || bus.error_o !== 1'b1) begin
            bad++; $display("FAIL full_saturate: scans=%0d acc=%0d err=%b required 69 68 1", n_scan,
                bus.accepted_count_o, bus.error_o);
        end
        do_reset();
        total++;
        if (bus.error_o !== 1'b0) begin bad++; $display("FAIL error_cleared: err=%b required 0", bus.error_o); end
    endtask

    task automatic test_backpressure();
        set_stash(3, 9);
        bp_mode = 1;
        run_access(16'h0BBB);
        bp_mode = 0;
        bus.writeback_ready_i = 1'b1;
        total++;
        if (n_dma != 68 || dma_seq_err != 0) begin
            bad++; $display("FAIL bp_dma: n=%0d seqerr=%0d required 68 0", n_dma, dma_seq_err);
        end
        total++;
        if (last_dma - first_dma != 134) begin
            bad++; $display("FAIL bp_span: got %0d required 134", last_dma - first_dma);
        end
        total++;
        if (bus.accepted_count_o !== 7'd7) begin bad++; $display("FAIL bp_acc: got %0d required 7", bus.accepted_count_o); end
    endtask

    task automatic test_latency3();
        set_stash(0, 5);
        st_valid[60]  = 1'b1;
        st_valid[127] = 1'b1;
        lat = 3'd3;
        run_access(16'h0C0C);
        total++;
        if (n_scan != 8 || scan_data_err != 0 || bus.accepted_count_o !== 7'd8 || bus.error_o !== 1'b0) begin
            bad++; $display("FAIL lat3_counts: scans=%0d dataerr=%0d acc=%0d err=%b required 8 0 8 0",
                n_scan, scan_data_err, bus.accepted_count_o, bus.error_o);
        end
        total++;
        if (last_rslt < 1 || wb_hist[last_rslt] !== 1'b1 || wb_hist[last_rslt + 1] !== 1'b0) begin
            bad++; $display("FAIL lat3_drain_end: last_rslt=%0d wb=%b,%b required 1,0", last_rslt,
                wb_hist[last_rslt], wb_hist[last_rslt + 1]);
        end
        total++;
        if (first_dma != last_rslt + 2) begin
            bad++; $display("FAIL lat3_dma_start: first_dma=%0d required %0d", first_dma, last_rslt + 2);
        end
        lat = 3'd1;
    endtask

    task automatic test_leaf_hold();
        set_stash(20, 25);
        inject = 1;
        run_access(16'hBEEF);
        inject = 0;
        total++;
        if (leaf_after !== 16'hBEEF || busy_after !== 1'b1) begin
            bad++; $display("FAIL hold_mid_dma: leaf=%h busy=%b required beef 1", leaf_after, busy_after);
        end
        total++;
        if (n_dma != 68 || dma_seq_err != 0) begin
            bad++; $display("FAIL hold_dma: n=%0d seqerr=%0d required 68 0", n_dma, dma_seq_err);
        end
        // Done is high now: a start here must be ignored
        bus.access_start_i = 1'b1;
        bus.access_leaf_i  = 16'h5555;
        @(negedge clk);
        bus.access_start_i = 1'b0;
        total++;
        if (bus.busy_o !== 1'b0 || bus.per_access_reset_o !== 1'b0 || bus.current_leaf_o !== 16'hBEEF) begin
            bad++; $display("FAIL hold_done_start: busy=%b par=%b leaf=%h required 0 0 beef", bus.busy_o,
                bus.per_access_reset_o, bus.current_leaf_o);
        end
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy_o !== 1'b0 || bus.accepted_count_o !== 7'd6) begin
            bad++; $display("FAIL hold_idle: busy=%b acc=%0d required 0 6", bus.busy_o, bus.accepted_count_o);
        end
    endtask

    initial begin
        bus.access_start_i     = 1'b0;
        bus.access_leaf_i      = 16'h0000;
        bus.table_reset_done_i = 1'b1;
        bus.writeback_ready_i  = 1'b1;
        bp_mode = 0;
        inject  = 0;
        set_stash(1, 0);
        test_reset();
        test_reset_mid_scan();
        test_rinit_hold();
        test_empty_stash();
        test_full_path();
        test_backpressure();
        test_latency3();
        test_leaf_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
